// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg
// Shared types and constants for the instruction encoder slice.
//   kind_e        request kind (R, I-ALU, lw, sw, beq, jal, two illegal codes)
//   OP_*          RV32I major opcodes produced by the encoder
//   IMMSRC_*      immediate-format codes, shared with the decoder
//   buf_state_e   occupancy of the two-entry output buffer
//   enc_entry_t   one encoded result as stored in the buffer
//   inRange       signed range helper for the optional immediate check
// Optional feature macro used by this slice: INSTR_ENC_RANGE_CHECK_EN
package instr_enc_pkg;

  typedef enum logic [2:0] {
    KIND_R    = 3'd0,
    KIND_I    = 3'd1,
    KIND_LW   = 3'd2,
    KIND_SW   = 3'd3,
    KIND_BEQ  = 3'd4,
    KIND_JAL  = 3'd5,
    KIND_ILL6 = 3'd6,
    KIND_ILL7 = 3'd7
  } kind_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] IMMSRC_I = 2'b00;
  localparam logic [1:0] IMMSRC_S = 2'b01;
  localparam logic [1:0] IMMSRC_B = 2'b10;
  localparam logic [1:0] IMMSRC_J = 2'b11;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  immsrc;
    logic        err;
  } enc_entry_t;

  // True when the signed value lies inside [lo, hi].
  function automatic logic inRange(input logic signed [31:0] v,
                                   input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/instr_enc_if.sv
// instr_enc_if
// Request/response bundle between a requester and the instruction encoder.
//   in_valid/in_ready     request handshake
//   in_kind, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm  request fields
//   out_valid/out_ready   response handshake
//   out_instr, out_immsrc, out_err                                  response fields
// Modports: slave = encoder side, master = requester/consumer side.
interface instr_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [1:0]  out_immsrc;
  logic        out_err;

  modport slave (
    input  in_valid, in_kind, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2,
           in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_immsrc, out_err
  );

  modport master (
    output in_valid, in_kind, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2,
           in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_immsrc, out_err
  );
endinterface

// File: rtl/instr_enc_field.sv
// instr_enc_field
// Combinational field packer: turns one request into a 32-bit RV32I word,
// its immediate-format code and an error flag.
//   i_kind, i_funct3, i_funct7b5, i_rd, i_rs1, i_rs2, i_imm  request fields
//   o_entry                                                   encoded result
// Macro INSTR_ENC_RANGE_CHECK_EN: when defined, an immediate that does not
// fit its field also raises err (the truncated encoding is still produced).
module instr_enc_field
  import instr_enc_pkg::*;
(
  input  logic [2:0]  i_kind,
  input  logic [2:0]  i_funct3,
  input  logic        i_funct7b5,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output enc_entry_t  o_entry
);

  kind_e w_kind;
  logic  w_rangeBad;

  assign w_kind = kind_e'(i_kind);

  // Immediate range check; branch and jump offsets must also be even.
`ifdef INSTR_ENC_RANGE_CHECK_EN
  always_comb begin
    w_rangeBad = 1'b0;
    case (w_kind)
      KIND_I, KIND_LW, KIND_SW: w_rangeBad = !inRange(i_imm, -2048, 2047);
      KIND_BEQ: w_rangeBad = !inRange(i_imm, -4096, 4094) || i_imm[0];
      KIND_JAL: w_rangeBad = !inRange(i_imm, -1048576, 1048574) || i_imm[0];
      default:  w_rangeBad = 1'b0;
    endcase
  end
`else
  logic w_unusedImmBits;
  assign w_unusedImmBits = &{1'b0, i_imm[31:21]};
  assign w_rangeBad      = 1'b0;
`endif

  // Field placement per format; unused register fields stay zero, lw/sw
  // and beq carry their fixed funct3 regardless of the request.
  always_comb begin
    o_entry = '0;
    case (w_kind)
      KIND_R: begin
        o_entry.instr  = {1'b0, i_funct7b5, 5'b00000, i_rs2, i_rs1, i_funct3,
                          i_rd, OP_R};
        o_entry.immsrc = IMMSRC_I;
      end
      KIND_I: begin
        o_entry.instr  = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_I};
        o_entry.immsrc = IMMSRC_I;
      end
      KIND_LW: begin
        o_entry.instr  = {i_imm[11:0], i_rs1, 3'b010, i_rd, OP_LW};
        o_entry.immsrc = IMMSRC_I;
      end
      KIND_SW: begin
        o_entry.instr  = {i_imm[11:5], i_rs2, i_rs1, 3'b010, i_imm[4:0], OP_SW};
        o_entry.immsrc = IMMSRC_S;
      end
      KIND_BEQ: begin
        o_entry.instr  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, 3'b000,
                          i_imm[4:1], i_imm[11], OP_BEQ};
        o_entry.immsrc = IMMSRC_B;
      end
      KIND_JAL: begin
        o_entry.instr  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                          i_rd, OP_JAL};
        o_entry.immsrc = IMMSRC_J;
      end
      default: begin
        o_entry.err = 1'b1;
      end
    endcase
    o_entry.err = o_entry.err | w_rangeBad;
  end

endmodule

// File: rtl/instr_enc.sv
// instr_enc
// RV32I instruction encoder with a two-entry output buffer.
//   clk, reset_n   clock and asynchronous active-low reset
//   bus (slave)    request fields + in_valid/in_ready,
//                  response out_instr/out_immsrc/out_err + out_valid/out_ready
// The head entry drives the outputs directly, so a stalled response holds
// steady. in_ready is a register and never depends on out_ready.
// Macro INSTR_ENC_RANGE_CHECK_EN enables immediate range errors (see
// instr_enc_field).
module instr_enc
  import instr_enc_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  instr_enc_if.slave  bus
);

  buf_state_e r_state;
  buf_state_e w_nextState;
  enc_entry_t r_head;
  enc_entry_t r_tail;
  enc_entry_t w_encEntry;
  logic       r_inReady;
  logic       w_push;
  logic       w_pop;

  instr_enc_field u_field (
    .i_kind     (bus.in_kind),
    .i_funct3   (bus.in_funct3),
    .i_funct7b5 (bus.in_funct7b5),
    .i_rd       (bus.in_rd),
    .i_rs1      (bus.in_rs1),
    .i_rs2      (bus.in_rs2),
    .i_imm      (bus.in_imm),
    .o_entry    (w_encEntry)
  );

  assign w_push = bus.in_valid && r_inReady;
  assign w_pop  = (r_state != BUF_EMPTY) && bus.out_ready;

  // Buffer occupancy next-state logic.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      BUF_EMPTY: if (w_push) w_nextState = BUF_ONE;
      BUF_ONE: begin
        if (w_push && !w_pop)      w_nextState = BUF_TWO;
        else if (w_pop && !w_push) w_nextState = BUF_EMPTY;
      end
      BUF_TWO:   if (w_pop) w_nextState = BUF_ONE;
      default:   w_nextState = BUF_EMPTY;
    endcase
  end

  // State register and a registered copy of "not full" for in_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= BUF_EMPTY;
      r_inReady <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_inReady <= (w_nextState != BUF_TWO);
    end
  end

  // Entry storage: head feeds the outputs, tail only fills when the head is
  // still waiting. A push into EMPTY, or a push with a pop in ONE, lands in
  // the head directly so latency stays at one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case (r_state)
        BUF_EMPTY: if (w_push) r_head <= w_encEntry;
        BUF_ONE: begin
          if (w_push && w_pop) r_head <= w_encEntry;
          else if (w_push)     r_tail <= w_encEntry;
        end
        BUF_TWO:   if (w_pop) r_head <= r_tail;
        default:   r_head <= r_head;
      endcase
    end
  end

  assign bus.in_ready   = r_inReady;
  assign bus.out_valid  = (r_state != BUF_EMPTY);
  assign bus.out_instr  = r_head.instr;
  assign bus.out_immsrc = r_head.immsrc;
  assign bus.out_err    = r_head.err;

endmodule

// File: tb/tb_instr_enc.sv
// tb_instr_enc
// Self-checking bench for instr_enc: directed vectors with known encodings,
// a backpressure stall, reset with a full buffer, and a short random run
// checked against an independent encoding model through a scoreboard queue.
// Honours INSTR_ENC_RANGE_CHECK_EN for the expected err values.
module tb_instr_enc;
  import instr_enc_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  immsrc;
    logic        err;
  } exp_t;

`ifdef INSTR_ENC_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  instr_enc_if bus ();

  instr_enc dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t        sbQ[$];
  exp_t        curExp;
  int          nCmp = 0;
  int          nFail = 0;
  bit          rdyArmed = 1'b0;
  bit          stallPrev = 1'b0;
  logic [31:0] heldInstr;
  logic [1:0]  heldImmsrc;
  logic        heldErr;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    nCmp++;
    assert (obs === expv) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Independent reference: builds each word by shifting masked fields.
  function automatic exp_t model(input logic [2:0] kind, input logic [2:0] f3,
                                 input logic f7, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm);
    exp_t e;
    logic [31:0] d, a, b, f;
    int s;
    d = 32'(rd);
    a = 32'(rs1);
    b = 32'(rs2);
    f = 32'(f3);
    s = int'($signed(imm));
    e.instr = 32'h0;
    e.immsrc = 2'b00;
    e.err = 1'b0;
    case (kind)
      3'd0: e.instr = 32'h33 | (d << 7) | (f << 12) | (a << 15) | (b << 20) |
                      (32'(f7) << 30);
      3'd1: begin
        e.instr = 32'h13 | (d << 7) | (f << 12) | (a << 15) | ((imm & 32'hFFF) << 20);
        e.err = RC && (s < -2048 || s > 2047);
      end
      3'd2: begin
        e.instr = 32'h03 | (d << 7) | (32'd2 << 12) | (a << 15) | ((imm & 32'hFFF) << 20);
        e.err = RC && (s < -2048 || s > 2047);
      end
      3'd3: begin
        e.instr = 32'h23 | ((imm & 32'h1F) << 7) | (32'd2 << 12) | (a << 15) |
                  (b << 20) | (((imm >> 5) & 32'h7F) << 25);
        e.immsrc = 2'b01;
        e.err = RC && (s < -2048 || s > 2047);
      end
      3'd4: begin
        e.instr = 32'h63 | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8) |
                  (a << 15) | (b << 20) | (((imm >> 5) & 32'h3F) << 25) |
                  (((imm >> 12) & 32'h1) << 31);
        e.immsrc = 2'b10;
        e.err = RC && (s < -4096 || s > 4094 || (imm & 32'h1) != 0);
      end
      3'd5: begin
        e.instr = 32'h6F | (d << 7) | (((imm >> 12) & 32'hFF) << 12) |
                  (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21) |
                  (((imm >> 20) & 32'h1) << 31);
        e.immsrc = 2'b11;
        e.err = RC && (s < -1048576 || s > 1048574 || (imm & 32'h1) != 0);
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic applyStimulus(input logic [2:0] kind, input logic [2:0] f3,
                               input logic f7, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm, input exp_t e);
    bus.in_valid    = 1'b1;
    bus.in_kind     = kind;
    bus.in_funct3   = f3;
    bus.in_funct7b5 = f7;
    bus.in_rd       = rd;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_imm      = imm;
    curExp          = e;
  endtask

  // One clock: check at the falling edge, track transfers, return #1 after
  // the rising edge.
  task automatic tick(output bit accepted);
    exp_t e;
    bit   pop;
    @(negedge clk);
    checkOutput("out_valid", 32'(bus.out_valid), 32'(sbQ.size() != 0));
    checkOutput("in_ready", 32'(bus.in_ready),
                32'(rdyArmed && reset_n && sbQ.size() != 2));
    if (stallPrev) begin
      checkOutput("hold_instr", bus.out_instr, heldInstr);
      checkOutput("hold_immsrc", 32'(bus.out_immsrc), 32'(heldImmsrc));
      checkOutput("hold_err", 32'(bus.out_err), 32'(heldErr));
    end
    pop      = bus.out_valid && bus.out_ready;
    accepted = bus.in_valid && bus.in_ready;
    if (pop && sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput("out_instr", bus.out_instr, e.instr);
      checkOutput("out_immsrc", 32'(bus.out_immsrc), 32'(e.immsrc));
      checkOutput("out_err", 32'(bus.out_err), 32'(e.err));
    end
    if (accepted) sbQ.push_back(curExp);
    stallPrev  = bus.out_valid && !bus.out_ready;
    heldInstr  = bus.out_instr;
    heldImmsrc = bus.out_immsrc;
    heldErr    = bus.out_err;
    @(posedge clk);
    #1;
    if (reset_n) rdyArmed = 1'b1;
  endtask

  // Offer the current request until accepted, within a cycle budget.
  task automatic sendReq(input int budget);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < budget && !acc; i++) tick(acc);
    if (!acc) checkOutput("accept_timeout", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit acc;
    bus.in_valid = 1'b0;
    for (int i = 0; i < budget && sbQ.size() > 0; i++) tick(acc);
    checkOutput("drain_left", 32'(sbQ.size()), 32'd0);
  endtask

  function automatic exp_t mk(input logic [31:0] instr, input logic [1:0] src,
                              input logic err);
    exp_t e;
    e.instr = instr;
    e.immsrc = src;
    e.err = err;
    return e;
  endfunction

  initial begin
    bit acc;
    logic [31:0] immPool [15];
    immPool = '{-32'sd2049, -32'sd2048, 32'sd2047, 32'sd2048, -32'sd4096,
                -32'sd4098, 32'sd4094, 32'sd4095, 32'sd4096, 32'sd1048574,
                32'sd1048576, -32'sd1048576, -32'sd1048578, 32'sd6, -32'sd4};

    bus.in_valid = 1'b0;
    bus.in_kind = '0;
    bus.in_funct3 = '0;
    bus.in_funct7b5 = 1'b0;
    bus.in_rd = '0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.in_imm = '0;
    bus.out_ready = 1'b0;
    reset_n = 1'b0;

    // Reset state.
    tick(acc);
    tick(acc);
    checkOutput("rst_instr", bus.out_instr, 32'h0);
    checkOutput("rst_immsrc", 32'(bus.out_immsrc), 32'h0);
    checkOutput("rst_err", 32'(bus.out_err), 32'h0);
    reset_n = 1'b1;
    tick(acc);
    checkOutput("ready_after_release", 32'(bus.in_ready), 32'd1);

    // Directed vectors, consumer always ready.
    bus.out_ready = 1'b1;
    applyStimulus(3'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, mk(32'h002081B3, 2'b00, 1'b0));
    sendReq(5);
    applyStimulus(3'd2, 3'b111, 1'b1, 5'd5, 5'd2, 5'd7, 32'd8, mk(32'h00812283, 2'b00, 1'b0));
    sendReq(5);
    applyStimulus(3'd3, 3'b000, 1'b0, 5'd9, 5'd2, 5'd5, -32'sd4, mk(32'hFE512E23, 2'b01, 1'b0));
    sendReq(5);
    applyStimulus(3'd5, 3'b011, 1'b0, 5'd1, 5'd3, 5'd4, 32'd2048, mk(32'h001000EF, 2'b11, 1'b0));
    sendReq(5);
    applyStimulus(3'd4, 3'b101, 1'b0, 5'd6, 5'd0, 5'd0, 32'd3, mk(32'h00000163, 2'b10, RC));
    sendReq(5);
    applyStimulus(3'd1, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd2048, mk(32'h80000013, 2'b00, RC));
    sendReq(5);
    applyStimulus(3'd6, 3'b010, 1'b1, 5'd7, 5'd8, 5'd9, 32'd12, mk(32'h0, 2'b00, 1'b1));
    sendReq(5);
    applyStimulus(3'd7, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, mk(32'h0, 2'b00, 1'b1));
    sendReq(5);
    applyStimulus(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd8, mk(32'hFE208CE3, 2'b10, 1'b0));
    sendReq(5);
    drain(10);

    // Backpressure: two accepted, third held off until the consumer drains.
    bus.out_ready = 1'b0;
    applyStimulus(3'd1, 3'b000, 1'b0, 5'd10, 5'd11, 5'd0, 32'd100,
                  model(3'd1, 3'b000, 1'b0, 5'd10, 5'd11, 5'd0, 32'd100));
    sendReq(5);
    applyStimulus(3'd0, 3'b101, 1'b1, 5'd12, 5'd13, 5'd14, 32'd0,
                  model(3'd0, 3'b101, 1'b1, 5'd12, 5'd13, 5'd14, 32'd0));
    sendReq(5);
    applyStimulus(3'd3, 3'b000, 1'b0, 5'd0, 5'd15, 5'd16, -32'sd20,
                  model(3'd3, 3'b000, 1'b0, 5'd0, 5'd15, 5'd16, -32'sd20));
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      checkOutput("stall_no_accept", 32'(acc), 32'd0);
    end
    bus.out_ready = 1'b1;
    sendReq(6);
    drain(10);

    // Reset with the buffer full discards both entries.
    bus.out_ready = 1'b0;
    applyStimulus(3'd5, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd64,
                  model(3'd5, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd64));
    sendReq(5);
    applyStimulus(3'd2, 3'b000, 1'b0, 5'd3, 5'd4, 5'd0, -32'sd1,
                  model(3'd2, 3'b000, 1'b0, 5'd3, 5'd4, 5'd0, -32'sd1));
    sendReq(5);
    tick(acc);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("midrst_instr", bus.out_instr, 32'h0);
    sbQ.delete();
    rdyArmed = 1'b0;
    stallPrev = 1'b0;
    bus.out_ready = 1'b1;
    tick(acc);
    tick(acc);
    reset_n = 1'b1;
    tick(acc);
    applyStimulus(3'd1, 3'b110, 1'b0, 5'd31, 5'd30, 5'd0, -32'sd2048,
                  model(3'd1, 3'b110, 1'b0, 5'd31, 5'd30, 5'd0, -32'sd2048));
    sendReq(5);
    drain(5);

    // Random requests with random backpressure.
    for (int n = 0; n < 24; n++) begin
      logic [2:0]  k;
      logic [2:0]  f3;
      logic        f7;
      logic [4:0]  rd, r1, r2;
      logic [31:0] im;
      k  = 3'($urandom_range(0, 7));
      f3 = 3'($urandom);
      f7 = 1'($urandom);
      rd = 5'($urandom);
      r1 = 5'($urandom);
      r2 = 5'($urandom);
      im = immPool[$urandom_range(0, 14)];
      applyStimulus(k, f3, f7, rd, r1, r2, im, model(k, f3, f7, rd, r1, r2, im));
      acc = 1'b0;
      for (int c = 0; c < 20 && !acc; c++) begin
        bus.out_ready = 1'($urandom_range(0, 3) != 0);
        tick(acc);
      end
      if (!acc) checkOutput("rand_accept_timeout", 32'(acc), 32'd1);
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
